// File: rtl/pid_param_loader.sv
// Frame decoder and PID parameter bank fed by the SPI shifter: validates each
// 32-bit frame, writes shadow registers and commits them while the PID core is idle.
module pid_param_loader #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          sck,
    input  logic [31:0]   frame_in,
    input  logic          pid_busy,
    output logic [PW-1:0] setpoint,
    output logic [PW-1:0] kp,
    output logic [PW-1:0] ki,
    output logic [PW-1:0] kd,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [7:0]    err_count,
    output logic          commit_pending
);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t        state, state_nxt;
    logic          sck_q;
    logic          cs_q;
    logic [5:0]    bit_cnt;
    logic [31:0]   cap_frame;
    logic [5:0]    cap_cnt;
    logic          eof;
    logic          check_en;
    logic          valid;
    logic          op;
    logic [1:0]    addr;
    logic [15:0]   data;
    logic [7:0]    csum;
    logic [PW-1:0] shadow [4];

    assign eof  = cs & ~cs_q;
    assign op   = cap_frame[27];
    assign addr = cap_frame[25:24];
    assign data = cap_frame[23:8];
    assign csum = cap_frame[31:24] ^ cap_frame[23:16] ^ cap_frame[15:8];

    assign valid = (cap_cnt == 6'd32)
                && (cap_frame[31:28] == 4'b1010)
                && !cap_frame[26]
                && (cap_frame[7:0] == csum)
                && (!op || (addr == 2'd0 && data == 16'd0));

    // Bit counter saturates at 33 so any overlong frame still reads as "not 32".
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            bit_cnt   <= 6'd0;
            cap_frame <= 32'd0;
            cap_cnt   <= 6'd0;
        end else begin
            cs_q <= cs;
            if (cs) begin
                sck_q   <= 1'b0;
                bit_cnt <= 6'd0;
            end else begin
                sck_q <= sck;
                if (!sck && sck_q && bit_cnt != 6'd33)
                    bit_cnt <= bit_cnt + 6'd1;
            end
            if (eof) begin
                cap_frame <= frame_in;
                cap_cnt   <= bit_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        check_en  = 1'b0;
        case (state)
            IDLE:  if (eof) state_nxt = CHECK;
            CHECK: begin
                check_en  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            err_count      <= 8'd0;
            commit_pending <= 1'b0;
            setpoint       <= '0;
            kp             <= '0;
            ki             <= '0;
            kd             <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            frame_ok  <= check_en & valid;
            frame_err <= check_en & ~valid;
            if (check_en && !valid && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (check_en && valid && !op)
                shadow[addr] <= data[PW-1:0];
            // Copy reads the pre-edge shadows; a same-edge write waits for the next commit.
            if (commit_pending && !pid_busy) begin
                setpoint       <= shadow[0];
                kp             <= shadow[1];
                ki             <= shadow[2];
                kd             <= shadow[3];
                commit_pending <= 1'b0;
            end
            // A fresh commit must survive a copy on the same edge.
            if (check_en && valid && op)
                commit_pending <= 1'b1;
        end
    end

endmodule

// File: doc/pid_param_loader.md
# pid_param_loader

Frame decoder and parameter register bank that sits directly downstream of the SPI input shifter. It watches the same `cs`/`sck` pins to count bits and detect end-of-frame. It latches the shifter's 32-bit parallel word, validates it (sync nibble, length, checksum) and writes 16-bit PID parameters into shadow registers. On a commit frame it copies all shadows into the active set at the next cycle where the PID core is not mid-calculation.

## Interface
Parameters:
- `PW`, 16: width of each parameter output, 1..16; takes the low `PW` bits of the data field.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `cs`  in  1: SPI chip select, active low, raw pin (same sampling as shifter).
- `sck`  in  1: SPI clock, raw pin.
- `frame_in`  in  32: parallel word from the SPI shifter; holds its value while `cs` is high.
- `pid_busy`  in  1: PID core is computing; active registers must not change while high.
- `setpoint`, `kp`, `ki`, `kd`  out  PW each: active parameters.
- `frame_ok`  out  1: one-cycle pulse, valid frame accepted.
- `frame_err`  out  1: one-cycle pulse, frame rejected.
- `err_count`  out  8: saturating rejected-frame count.
- `commit_pending`  out  1: commit accepted, copy not yet done.

## Operation
- Frame format (bit 31 first on wire): [31:28] sync = 4'b1010; [27] op (0 = write shadow, 1 = commit); [26] reserved, must be 0; [25:24] addr (0 setpoint, 1 kp, 2 ki, 3 kd); [23:8] data; [7:0] checksum = frame[31:24] ^ frame[23:16] ^ frame[15:8].
- Bit counter: 6 bits. Registers `sck_q`. While `cs` low, increments on each `sck` falling edge (`sck`=0, `sck_q`=1) and saturates at 33. When `cs` high, counter and `sck_q` are cleared.
- End of frame: `cs`=1 and `cs_q`=0 at a clock edge (T0). At T0, `frame_in` and the bit count load into capture registers. `cs_q` resets to 1.
- FSM: IDLE -> CHECK on end-of-frame; CHECK -> IDLE unconditionally after 1 cycle.
- In CHECK, the frame is valid iff count == 32, sync ok, reserved bit 0, and checksum ok. Op = 1 additionally requires addr == 0 and data == 0.
- Valid write: shadow[addr] <= data[PW-1:0]; `frame_ok` pulses.
- Valid commit: `commit_pending` <= 1; `frame_ok` pulses.
- Invalid frame: no register change; `frame_err` pulses; `err_count` increments, holds at 255.
- Commit copy: at any edge where `commit_pending`=1 and `pid_busy`=0, all four active regs <= shadows and `commit_pending` <= 0.
- Reset values: active regs, shadows, `err_count`, `frame_ok`, `frame_err`, `commit_pending` all 0. FSM resets to IDLE; counter resets to 0.

## Timing
- T0: edge detected and capture registers loaded. T1: CHECK state; `frame_ok`/`frame_err`, shadow write, `commit_pending` set and `err_count` update all register at the T1 edge and are visible after T1 for one cycle.
- Earliest active update after a commit frame is the T2 edge. The copy is delayed by any number of cycles while `pid_busy`=1.
- A commit arriving while `commit_pending`=1 leaves it set. Shadow writes made while pending are included in the eventual copy, which always uses the latest shadows.
- A shadow write and a commit copy at the same edge: the copy uses the old shadow value; the new value waits for the next commit.
- Requirement on the master: `sck` idle for ≥ 2 clk before `cs` rises, so the shifter's last shift has landed in `frame_in` by T0.
- Back-to-back frames: `cs` high for ≥ 2 clk between frames. A `cs` glitch shorter than this still produces exactly one evaluation per rising edge.
- Reset mid-frame: everything clears. A frame in progress at reset release yields count ≠ 32, so it is rejected with `frame_err`.
- Counts above 32 (saturated at 33) and below 32 are both rejected.

## Test plan
- Write kp: 32 bits of 0xA1123487, then cs rise -> `frame_ok` at T1, `kp` unchanged. Then send 0xA80000A8 with `pid_busy`=0 -> `kp`=0x1234 after T2, `commit_pending` 0.
- Bad checksum 0xA1123488 -> `frame_err` pulse, `err_count`=1, shadows unchanged. Bad sync 0x51123446 -> `err_count`=2.
- Short frame: 31 bits then cs rise -> `frame_err`. Long frame: 33 bits -> `frame_err`.
- Commit sent while `pid_busy`=1 for 10 cycles -> `commit_pending`=1, actives unchanged throughout; copy occurs on the first edge with `pid_busy`=0.
- Force 300 invalid frames -> `err_count` holds at 255.
- Assert reset for 1 cycle mid-frame after 16 bits -> all outputs 0. The completing cs rise gives `frame_err`, and `err_count`=1.
